set_assoc_cache: RTL and testbench
==================================

# set_assoc_cache

Parametrised N-way set-associative, write-back, write-allocate cache with true-LRU replacement and a line-wide memory refill/writeback handshake. It sits between a single requester (CPU/DMA port) and the line-wide memory controller, and is the generalised successor of the team's direct-mapped cache. Unlike that block, it owns the miss sequence itself: it writes back the dirty victim, refills the line and completes the request without requester involvement.

## Interface
- BLOCK_SIZE, 32, bits per word
- BLOCKS_PER_LINE, 4, words per line, power of 2, ≥2
- NUM_SETS, 4, sets, power of 2, ≥2
- NUM_WAYS, 2, ways per set, power of 2, ≥2
- ADDRESS_SIZE, 32, word-address width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  cache accepts request (high only in IDLE)
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDRESS_SIZE  word address {tag, index, offset}
- req_wdata  in  BLOCK_SIZE  write word
- resp_valid  out  1  one-cycle pulse, request complete
- resp_rdata  out  BLOCK_SIZE  read word, valid with resp_valid (unchanged on writes)
- resp_hit  out  1  1 if completed without memory traffic
- mem_req  out  1  memory transaction pending
- mem_we  out  1  1 = line writeback, 0 = line fetch
- mem_addr  out  ADDRESS_SIZE  line-aligned address, offset bits zero
- mem_wline  out  BLOCKS_PER_LINE*BLOCK_SIZE  writeback line, word 0 in LSBs
- mem_ack  in  1  one-cycle completion; sampled only while mem_req=1
- mem_rline  in  BLOCKS_PER_LINE*BLOCK_SIZE  fetched line, valid with mem_ack

## Operation
- Widths: OFFSET_W = log2(BLOCKS_PER_LINE), INDEX_W = log2(NUM_SETS), TAG_W = ADDRESS_SIZE − INDEX_W − OFFSET_W. Word k of a line occupies bits [k*BLOCK_SIZE +: BLOCK_SIZE].
- Per way per set: valid, dirty, tag, data line, LRU age (log2 NUM_WAYS bits).
- FSM states: IDLE, COMPARE, WRITEBACK, REFILL.
- IDLE: req_ready=1. On req_valid, latch we/addr/wdata and go to COMPARE.
- COMPARE: hit = any way with valid and matching tag. Multiple tag matches cannot occur.
  - Read hit: return the addressed word.
  - Write hit: write the word and set dirty.
  - On either hit: pulse resp_valid, update LRU, return to IDLE. resp_hit=1 unless the request passed through REFILL.
  - Miss, victim not dirty: go to REFILL.
  - Miss, victim dirty: go to WRITEBACK.
- Victim selection: lowest-index invalid way; if all ways are valid, the way with age NUM_WAYS−1.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wline=victim data. On mem_ack, go to REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr={req tag, index, 0}. On mem_ack, install mem_rline into the victim way with valid=1, dirty=0, tag=req tag, then return to COMPARE, which now hits.
- LRU update on every completed access: accessed way age←0; each other way in the set with age < old age increments; older ways are unchanged. Ages stay a permutation of 0..NUM_WAYS−1.
- Reset: all valid/dirty cleared, way w age=w in every set, state IDLE. Data arrays are not cleared.
- Reset mid-miss: mem_req drops in the cycle after the reset edge. Any partial refill is discarded.

## Timing
- Hit latency: accept at edge N; resp_valid high during cycle N+1 to N+2.
- Clean miss: resp_valid in the cycle after the COMPARE that follows mem_ack.
- Dirty miss: writeback and refill are serialised; mem_req stays continuously high across the WRITEBACK→REFILL transition, and mem_we/mem_addr change on the ack edge.
- mem_req, mem_we, mem_addr and mem_wline are registered and stable until mem_ack.
- req_ready=0 outside IDLE. Requests are not queued.
- Reset values: req_ready=0 during reset and 1 after it; resp_valid=0, resp_rdata=0, resp_hit=0, mem_req=0, mem_we=0, mem_addr=0, mem_wline=0.

## Structure
- Package cache_pkg: FSM state enum and a log2 width helper. Field widths are derived from the parameters.
- Sub-module cache_lru: holds the age array for one set index. Provides access update and victim selection, taking the valid vector as input.

## Test plan
- 2-way, 4 sets. Read 0x40 after reset → miss. Expect REFILL with mem_addr=0x40 and resp_rdata=word 0 of the fetched line, resp_hit=0. An immediate re-read of 0x41 → resp_hit=1, resp_rdata=word 1, resp_valid in the second cycle.
- Write 0xDEADBEEF to 0x40, then read 0x40 → hit returns 0xDEADBEEF and no memory traffic occurs.
- Fill set 0 with tags A and B, touch A, then access tag C → B is evicted. If B was dirty, a writeback with B's line precedes the refill, with mem_req held high throughout.
- Dirty victim with mem_ack delayed 5 cycles → mem_addr and mem_wline are held stable for 5 cycles, and req_ready=0 throughout.
- Assert rst_n=0 during REFILL → mem_req=0 on the next cycle. A subsequent read of the same address misses.
- Send req_valid during a miss → not accepted; it is accepted on the first IDLE cycle.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache: FSM state encoding and
// a constant-foldable log2 helper used to derive address field widths.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    REFILL    = 2'd3
  } cache_state_e;

  function automatic int log2w(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/set_assoc_cache_if.sv
// Requester and line-wide memory handshake bundle. The cache is the slave
// side; the environment (requester plus memory controller) is the master.
interface set_assoc_cache_if #(
  parameter int BLOCK_SIZE      = 32,
  parameter int BLOCKS_PER_LINE = 4,
  parameter int ADDRESS_SIZE    = 32
);
  localparam int LINE_W = BLOCKS_PER_LINE * BLOCK_SIZE;

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDRESS_SIZE-1:0] req_addr;
  logic [BLOCK_SIZE-1:0]   req_wdata;
  logic                    resp_valid;
  logic [BLOCK_SIZE-1:0]   resp_rdata;
  logic                    resp_hit;
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic [LINE_W-1:0]       mem_wline;
  logic                    mem_ack;
  logic [LINE_W-1:0]       mem_rline;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rline,
    output req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_we, mem_addr, mem_wline
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rline,
    input  req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_we, mem_addr, mem_wline
  );

endinterface

// File: rtl/cache_lru.sv
// True-LRU age tracking for a single set: ages form a permutation of
// 0..NUM_WAYS-1, with 0 the most recently used way.
module cache_lru
  import cache_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  localparam int WAY_W   = log2w(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                access_en,
  input  logic [WAY_W-1:0]    access_way,
  input  logic [NUM_WAYS-1:0] valid,
  output logic [WAY_W-1:0]    victim
);

  localparam logic [WAY_W-1:0] OLDEST = WAY_W'(NUM_WAYS - 1);

  logic [WAY_W-1:0] age_q [NUM_WAYS];
  logic [WAY_W-1:0] age_d [NUM_WAYS];
  logic             found;

  always_comb begin
    age_d = age_q;
    if (access_en) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == access_way)
          age_d[w] = '0;
        else if (age_q[w] < age_q[access_way])
          age_d[w] = age_q[w] + 1'b1;
      end
    end
  end

  // Empty ways are filled first so a cold set never evicts live data.
  always_comb begin
    found  = 1'b0;
    victim = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && !valid[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_q[w] == OLDEST) victim = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WAYS; w++) age_q[w] <= WAY_W'(w);
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back, write-allocate cache. Owns the whole
// miss sequence: dirty-victim writeback, line refill, then a re-compare.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int BLOCK_SIZE      = 32,
  parameter int BLOCKS_PER_LINE = 4,
  parameter int NUM_SETS        = 4,
  parameter int NUM_WAYS        = 2,
  parameter int ADDRESS_SIZE    = 32
) (
  input logic               clk,
  input logic               rst_n,
  set_assoc_cache_if.slave  bus
);

  localparam int OFFSET_W = log2w(BLOCKS_PER_LINE);
  localparam int INDEX_W  = log2w(NUM_SETS);
  localparam int TAG_W    = ADDRESS_SIZE - INDEX_W - OFFSET_W;
  localparam int WAY_W    = log2w(NUM_WAYS);
  localparam int LINE_W   = BLOCKS_PER_LINE * BLOCK_SIZE;

  cache_state_e            state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [BLOCK_SIZE-1:0]   wdata_q, wdata_d;
  logic                    refilled_q, refilled_d;
  logic [WAY_W-1:0]        victim_q, victim_d;

  logic                    resp_valid_q, resp_valid_d;
  logic [BLOCK_SIZE-1:0]   resp_rdata_q, resp_rdata_d;
  logic                    resp_hit_q, resp_hit_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDRESS_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]       mem_wline_q, mem_wline_d;

  logic [NUM_WAYS-1:0]     valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]     valid_d [NUM_SETS];
  logic [NUM_WAYS-1:0]     dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0]     dirty_d [NUM_SETS];
  logic [TAG_W-1:0]        tag_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]        tag_d   [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]       data_q  [NUM_SETS][NUM_WAYS];
  logic [LINE_W-1:0]       data_d  [NUM_SETS][NUM_WAYS];

  logic [OFFSET_W-1:0]     req_off;
  logic [INDEX_W-1:0]      req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic                    hit;
  logic [WAY_W-1:0]        hit_way;
  logic [WAY_W-1:0]        set_victim [NUM_SETS];
  logic [WAY_W-1:0]        victim_sel;
  logic                    lru_en;

  assign req_off    = addr_q[OFFSET_W-1:0];
  assign req_idx    = addr_q[OFFSET_W +: INDEX_W];
  assign req_tag    = addr_q[ADDRESS_SIZE-1 -: TAG_W];
  assign victim_sel = set_victim[req_idx];

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_lru
    cache_lru #(.NUM_WAYS(NUM_WAYS)) u_lru (
      .clk       (clk),
      .rst_n     (rst_n),
      .access_en (lru_en && (req_idx == INDEX_W'(s))),
      .access_way(hit_way),
      .valid     (valid_q[s]),
      .victim    (set_victim[s])
    );
  end

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // The second COMPARE after a refill always hits, but is reported as a miss.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    refilled_d   = refilled_q;
    victim_d     = victim_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_hit_d   = resp_hit_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wline_d  = mem_wline_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    data_d       = data_q;
    lru_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d       = bus.req_we;
          addr_d     = bus.req_addr;
          wdata_d    = bus.req_wdata;
          refilled_d = 1'b0;
          state_d    = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = !refilled_q;
          lru_en       = 1'b1;
          if (we_q) begin
            data_d[req_idx][hit_way][req_off*BLOCK_SIZE +: BLOCK_SIZE] = wdata_q;
            dirty_d[req_idx][hit_way] = 1'b1;
          end else begin
            resp_rdata_d = data_q[req_idx][hit_way][req_off*BLOCK_SIZE +: BLOCK_SIZE];
          end
          state_d = IDLE;
        end else begin
          victim_d  = victim_sel;
          mem_req_d = 1'b1;
          if (valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel]) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[req_idx][victim_sel], req_idx, {OFFSET_W{1'b0}}};
            mem_wline_d = data_q[req_idx][victim_sel];
            state_d     = WRITEBACK;
          end else begin
            mem_we_d   = 1'b0;
            mem_addr_d = {req_tag, req_idx, {OFFSET_W{1'b0}}};
            state_d    = REFILL;
          end
        end
      end
      WRITEBACK: begin
        if (mem_req_q && bus.mem_ack) begin
          mem_we_d   = 1'b0;
          mem_addr_d = {req_tag, req_idx, {OFFSET_W{1'b0}}};
          state_d    = REFILL;
        end
      end
      REFILL: begin
        if (mem_req_q && bus.mem_ack) begin
          mem_req_d                  = 1'b0;
          data_d[req_idx][victim_q]  = bus.mem_rline;
          tag_d[req_idx][victim_q]   = req_tag;
          valid_d[req_idx][victim_q] = 1'b1;
          dirty_d[req_idx][victim_q] = 1'b0;
          refilled_d                 = 1'b1;
          state_d                    = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      refilled_q   <= 1'b0;
      victim_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_hit_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wline_q  <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      refilled_q   <= refilled_d;
      victim_q     <= victim_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_hit_q   <= resp_hit_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wline_q  <= mem_wline_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
    end
  end

  // Tags and data need no reset; valid bits gate every use of them.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign bus.req_ready  = rst_n && (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wline  = mem_wline_q;

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache (2 ways, 4 sets, 4 words per line)
// with a behavioural line memory whose ack delay is set per step.
module tb_set_assoc_cache;

  logic clk;
  logic rst_n;

  set_assoc_cache_if #(.BLOCK_SIZE(32), .BLOCKS_PER_LINE(4), .ADDRESS_SIZE(32)) bus ();

  set_assoc_cache #(
    .BLOCK_SIZE(32), .BLOCKS_PER_LINE(4), .NUM_SETS(4), .NUM_WAYS(2), .ADDRESS_SIZE(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int ack_delay = 0;
  int wb_count = 0;
  int rf_count = 0;
  logic [31:0]  wb_addr = '0;
  logic [127:0] wb_line = '0;
  logic [31:0]  rf_addr = '0;

  function automatic logic [127:0] mkLine(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = 32'hA000_0000 | (a << 4) | 32'(k);
    return l;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Line memory: acks ack_delay cycles after it sees mem_req, for one cycle.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rline = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        wait_cnt    = 0;
      end else if (bus.mem_req === 1'b1) begin
        if (wait_cnt >= ack_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rline = mkLine(bus.mem_addr);
          if (bus.mem_we) begin
            wb_count++;
            wb_addr = bus.mem_addr;
            wb_line = bus.mem_wline;
          end else begin
            rf_count++;
            rf_addr = bus.mem_addr;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic waitResp(output int n);
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("resp_timeout", 128'(n < 200), 128'(1));
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output logic hit, output int lat);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    waitResp(lat);
    rdata = bus.resp_rdata;
    hit   = bus.resp_hit;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0]  rdata;
    logic         hit;
    int           lat;
    int           n;
    int           wb_before;
    int           rf_before;
    logic         flag;
    logic [127:0] exp_line;

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", bus.req_ready, 0);
    checkOutput("rst_resp_valid", bus.resp_valid, 0);
    checkOutput("rst_resp_rdata", bus.resp_rdata, 0);
    checkOutput("rst_resp_hit", bus.resp_hit, 0);
    checkOutput("rst_mem_req", bus.mem_req, 0);
    checkOutput("rst_mem_we", bus.mem_we, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    checkOutput("rst_mem_wline", bus.mem_wline, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_req_ready", bus.req_ready, 1);

    // Cold read miss, then a hit to the neighbouring word
    applyStimulus(1'b0, 32'h40, 32'h0, rdata, hit, lat);
    checkOutput("cold_rdata", rdata, 32'hA000_0400);
    checkOutput("cold_hit", hit, 0);
    checkOutput("cold_refill_addr", rf_addr, 32'h40);
    checkOutput("cold_refills", rf_count, 1);
    checkOutput("cold_latency", lat, 3);
    applyStimulus(1'b0, 32'h41, 32'h0, rdata, hit, lat);
    checkOutput("hit_rdata", rdata, 32'hA000_0401);
    checkOutput("hit_flag", hit, 1);
    checkOutput("hit_latency", lat, 1);
    @(posedge clk); #1;
    checkOutput("resp_pulse_ends", bus.resp_valid, 0);

    // Write hit then read back with no memory traffic
    rf_before = rf_count;
    wb_before = wb_count;
    applyStimulus(1'b1, 32'h40, 32'hDEAD_BEEF, rdata, hit, lat);
    checkOutput("whit_flag", hit, 1);
    applyStimulus(1'b0, 32'h40, 32'h0, rdata, hit, lat);
    checkOutput("wread_rdata", rdata, 32'hDEAD_BEEF);
    checkOutput("wread_hit", hit, 1);
    checkOutput("wread_no_traffic", 32'(rf_count - rf_before + wb_count - wb_before), 0);

    // Fill set 0 with B (0x80), dirty it, touch A (0x40)
    applyStimulus(1'b0, 32'h80, 32'h0, rdata, hit, lat);
    checkOutput("fillb_rdata", rdata, 32'hA000_0800);
    checkOutput("fillb_no_wb", wb_count, wb_before);
    applyStimulus(1'b1, 32'h83, 32'h1234_5678, rdata, hit, lat);
    checkOutput("dirtyb_hit", hit, 1);
    applyStimulus(1'b0, 32'h42, 32'h0, rdata, hit, lat);
    checkOutput("toucha_rdata", rdata, 32'hA000_0402);

    // C (0xC0) evicts dirty B with a slow memory
    ack_delay = 5;
    exp_line  = {32'h1234_5678, 32'hA000_0802, 32'hA000_0801, 32'hA000_0800};
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'hC0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    flag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h80 ||
          bus.mem_wline !== exp_line || bus.req_ready !== 1'b0) flag = 1'b1;
      @(posedge clk); #1;
    end
    checkOutput("wb_held_stable", flag, 0);
    flag = 1'b0;
    n = 0;
    while (bus.mem_we !== 1'b0 && n < 50) begin
      if (bus.mem_req !== 1'b1) flag = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    checkOutput("wb_to_refill_req_held", {flag, bus.mem_req}, 2'b01);
    checkOutput("refill_c_addr", bus.mem_addr, 32'hC0);
    waitResp(lat);
    checkOutput("evict_rdata", bus.resp_rdata, 32'hA000_0C00);
    checkOutput("evict_hit", bus.resp_hit, 0);
    checkOutput("evict_wb_addr", wb_addr, 32'h80);
    checkOutput("evict_wb_line", wb_line, exp_line);
    ack_delay = 0;

    // B was evicted: re-read misses and now pushes out dirty A
    wb_before = wb_count;
    applyStimulus(1'b0, 32'h80, 32'h0, rdata, hit, lat);
    checkOutput("b_gone_hit", hit, 0);
    checkOutput("b_gone_rdata", rdata, 32'hA000_0800);
    checkOutput("a_wb_count", wb_count, wb_before + 1);
    checkOutput("a_wb_addr", wb_addr, 32'h40);
    checkOutput("a_wb_line", wb_line,
                {32'hA000_0403, 32'hA000_0402, 32'hA000_0401, 32'hDEAD_BEEF});

    // Request held during a miss is taken only on the first IDLE cycle
    ack_delay = 3;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h100;
    @(posedge clk); #1;
    bus.req_addr = 32'h81;
    flag = 1'b0;
    n = 0;
    while (bus.resp_valid !== 1'b1 && n < 200) begin
      if (bus.req_ready !== 1'b0) flag = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    checkOutput("busy_not_ready", flag, 0);
    checkOutput("busy_first_rdata", bus.resp_rdata, 32'hA000_1000);
    checkOutput("busy_ready_in_idle", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checkOutput("queued_accepted", {bus.req_ready, bus.resp_valid}, 2'b00);
    @(posedge clk); #1;
    checkOutput("queued_resp", {bus.resp_valid, bus.resp_hit}, 2'b11);
    checkOutput("queued_rdata", bus.resp_rdata, 32'hA000_0801);

    // Reset in the middle of a refill
    ack_delay = 50;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h200;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("midrst_refill", {bus.mem_we, bus.mem_addr}, {1'b0, 32'h200});
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_mem_req", bus.mem_req, 0);
    checkOutput("midrst_ready", bus.req_ready, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    ack_delay = 0;
    applyStimulus(1'b0, 32'h200, 32'h0, rdata, hit, lat);
    checkOutput("postrst_hit", hit, 0);
    checkOutput("postrst_rdata", rdata, 32'hA000_2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
